// File: rtl/ddma_rx.sv
// Receive-side DMA engine: unpacks one router packet and writes its
// payload flits to memory as little-endian word pairs.
module ddma_rx #(
  parameter int FLIT_WIDTH       = 16,
  parameter int MEMORY_BUS_WIDTH = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rx,
  input  logic [FLIT_WIDTH-1:0]       data_i,
  output logic                        credit_o,
  input  logic                        cmd_in,
  input  logic [MEMORY_BUS_WIDTH-1:0] addr_in,
  input  logic [MEMORY_BUS_WIDTH-1:0] nbytes_in,
  output logic [1:0]                  status_out,
  output logic                        irq_out,
  output logic                        mem_enable_out,
  output logic [3:0]                  mem_wb_out,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_addr_out,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_data_out
);

  localparam int FW = FLIT_WIDTH;
  localparam int MW = MEMORY_BUS_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SIZE,
    S_RECV,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t        state;
  logic [MW-1:0] addr_q;
  logic [MW-1:0] cap_q;
  logic [MW-1:0] idx_q;
  logic [FW-1:0] rem_q;
  logic [FW-1:0] low_q;
  logic          pend_q;
  logic          ovf_q;

  logic          accept;
  logic          in_cap;
  logic          last;
  logic          pend_nx;

  assign credit_o = (state == S_HDR) ||
                    (state == S_SIZE) ||
                    (state == S_RECV);
  assign irq_out  = (state == S_DONE);
  assign accept   = rx && credit_o;
  assign in_cap   = idx_q < cap_q;
  assign last     = rem_q == FW'(1);

  always_comb begin
    status_out = 2'd1;
    unique case (1'b1)
      state == S_IDLE: status_out = 2'd0;
      state == S_DONE: status_out = ovf_q ? 2'd3 : 2'd2;
      default:         status_out = 2'd1;
    endcase
  end

  // Pending-half flag as it will stand after the current payload flit
  always_comb begin
    pend_nx = pend_q;
    if (in_cap) pend_nx = ~idx_q[0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      addr_q         <= '0;
      cap_q          <= '0;
      idx_q          <= '0;
      rem_q          <= '0;
      low_q          <= '0;
      pend_q         <= 1'b0;
      ovf_q          <= 1'b0;
      mem_enable_out <= 1'b0;
      mem_wb_out     <= '0;
      mem_addr_out   <= '0;
      mem_data_out   <= '0;
    end else begin
      mem_enable_out <= 1'b0;
      mem_wb_out     <= '0;
      unique case (state)
        S_IDLE: begin
          if (cmd_in) begin
            addr_q <= addr_in;
            cap_q  <= {1'b0, nbytes_in[MW-1:1]};
            idx_q  <= '0;
            rem_q  <= '0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
            state  <= S_HDR;
          end
        end
        S_HDR: begin
          if (accept) state <= S_SIZE;
        end
        S_SIZE: begin
          if (accept) begin
            rem_q <= data_i;
            state <= (data_i == '0) ? S_DONE : S_RECV;
          end
        end
        S_RECV: begin
          if (accept) begin
            rem_q <= rem_q - FW'(1);
            idx_q <= idx_q + MW'(1);
            pend_q <= pend_nx;
            if (!in_cap) begin
              ovf_q <= 1'b1;
            end else if (!idx_q[0]) begin
              low_q <= data_i;
            end else begin
              mem_enable_out <= 1'b1;
              mem_wb_out     <= 4'b1111;
              mem_addr_out   <= addr_q;
              mem_data_out   <= {data_i, low_q};
              addr_q         <= addr_q + MW'(4);
            end
            if (last) state <= pend_nx ? S_FLUSH : S_DONE;
          end
        end
        S_FLUSH: begin
          mem_enable_out <= 1'b1;
          mem_wb_out     <= 4'b0011;
          mem_addr_out   <= addr_q;
          mem_data_out   <= {{FW{1'b0}}, low_q};
          addr_q         <= addr_q + MW'(4);
          pend_q         <= 1'b0;
          state          <= S_DONE;
        end
        S_DONE: begin
          if (!cmd_in) begin
            ovf_q  <= 1'b0;
            pend_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ddma_rx.md
DDMA_RX -- requirements
Module: ddma_rx

Interface
REQ-001 Parameter FLIT_WIDTH, default 16, router flit width in bits.
REQ-002 Parameter MEMORY_BUS_WIDTH, default 32, memory data/address width; SHALL equal 2*FLIT_WIDTH.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 rx  in  1  router flit valid.
REQ-006 data_i  in  FLIT_WIDTH  incoming flit.
REQ-007 credit_o  out  1  receiver can accept a flit this cycle.
REQ-008 cmd_in  in  1  arm request (1) / acknowledge (drop to 0).
REQ-009 addr_in  in  MEMORY_BUS_WIDTH  destination byte address; word-aligned.
REQ-010 nbytes_in  in  MEMORY_BUS_WIDTH  destination buffer capacity in bytes.
REQ-011 status_out  out  2  0 IDLE, 1 BUSY, 2 DONE, 3 DONE_OVERFLOW.
REQ-012 irq_out  out  1  completion interrupt.
REQ-013 mem_enable_out  out  1  memory write strobe, one cycle per word.
REQ-014 mem_wb_out  out  4  byte write enables.
REQ-015 mem_addr_out  out  MEMORY_BUS_WIDTH  write byte address.
REQ-016 mem_data_out  out  MEMORY_BUS_WIDTH  write data.

Function
REQ-017 A flit SHALL be accepted only at a rising edge where rx=1 and credit_o=1; rx while credit_o=0 SHALL be ignored.
REQ-018 Packet format: header flit (discarded), size flit N (payload flit count, unsigned), then N payload flits.
REQ-019 States: IDLE, WAIT_HDR, WAIT_SIZE, RECV, FLUSH, DONE.
REQ-020 IDLE: cmd_in=1 -> latch addr_in, nbytes_in; capacity C = floor(nbytes_in/2) flits; go WAIT_HDR.
REQ-021 WAIT_HDR: accepted flit -> WAIT_SIZE.
REQ-022 WAIT_SIZE: accepted flit -> N latched; N=0 -> DONE; else RECV.
REQ-023 RECV: each accepted flit decrements remaining count; last flit -> FLUSH if a partial word is pending, else DONE.
REQ-024 credit_o SHALL be 1 exactly in WAIT_HDR, WAIT_SIZE, RECV; 0 otherwise.
REQ-025 Packing little-endian: even-indexed payload flit -> bits [FLIT_WIDTH-1:0], odd-indexed -> upper half.
REQ-026 On acceptance of an odd-indexed flit within capacity, next cycle SHALL assert mem_enable_out=1, mem_wb_out=4'b1111, current address, packed word; address then += 4.
REQ-027 FLUSH: one write of the pending even flit, upper half zero, mem_wb_out=4'b0011; then DONE.
REQ-028 Payload flits with index >= C SHALL be accepted and discarded (no write) and set a sticky overflow flag.
REQ-029 Memory is assumed always ready; no write stall; at most one write per cycle.
REQ-030 mem_enable_out, mem_wb_out SHALL be 0 in every cycle without a write; mem_addr_out/mem_data_out hold last value.
REQ-031 status_out: IDLE->0; WAIT_HDR/WAIT_SIZE/RECV/FLUSH->1; DONE->2, or 3 if overflow flag set.
REQ-032 DONE: irq_out=1 from the cycle DONE is entered; held until cmd_in=0, then irq_out=0, flags cleared, state IDLE next cycle.
REQ-033 cmd_in changes outside IDLE and DONE SHALL be ignored (no re-arm mid-packet).

Reset
REQ-034 reset=0 SHALL immediately force state IDLE and all outputs to 0, discard any pending partial word, clear overflow flag, including mid-packet.

Verification
REQ-035 Reset asserted mid-RECV -> all outputs 0 at once, no further writes, credit_o=0 until re-armed.
REQ-036 addr=0x100, nbytes=8, packet {H,4,0xA1,0xA2,0xA3,0xA4} -> writes 0x100=0xA200A1 wb 1111, 0x104=0xA400A3 wb 1111; status 2, irq 1.
REQ-037 addr=0x40, nbytes=8, size 3 {0x11,0x22,0x33} -> 0x40=0x00220011 wb 1111, 0x44=0x00000033 wb 0011; status 2.
REQ-038 nbytes=4, size 4 -> single write at addr, two flits dropped, credit_o stays 1 through packet, status 3.
REQ-039 size 0 -> no mem_enable_out pulse, DONE next cycle, irq 1; cmd_in=0 -> irq 0, status 0.
REQ-040 rx pulses while IDLE or DONE (credit_o=0) -> no state change, no writes.
